// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : boot_pkg
//  Purpose  : Shared definitions for the UART boot loader: loader state
//             encoding, default frame start marker and bit-period helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Loader FSM encoding
  typedef logic [2:0] boot_state_t;
  localparam boot_state_t ST_IDLE   = 3'd0;
  localparam boot_state_t ST_LEN_LO = 3'd1;
  localparam boot_state_t ST_LEN_HI = 3'd2;
  localparam boot_state_t ST_DATA   = 3'd3;
  localparam boot_state_t ST_CHECK  = 3'd4;
  localparam boot_state_t ST_RUN    = 3'd5;
  localparam boot_state_t ST_ERROR  = 3'd6;

  // Clocks per UART bit, integer-truncated
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with 2-flop synchronizer and start-bit
//             glitch rejection.
//  Ports    : clk, reset (async active-low), rx (serial in),
//             byte_out[7:0], byte_valid (1-cycle pulse),
//             frame_err (1-cycle pulse when stop bit is 0)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [1:0]  RX_IDLE  = 2'd0;
  localparam logic [1:0]  RX_START = 2'd1;
  localparam logic [1:0]  RX_DATA  = 2'd2;
  localparam logic [1:0]  RX_STOP  = 2'd3;
  localparam logic [15:0] C_HALF   = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] C_FULL   = 16'(CLKS_PER_BIT);

  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        // falling edge on the synchronized line
        if (prev_q && !sync2_q) begin
          st_d  = RX_START;
          cnt_d = 16'd0;
        end
      end
      RX_START: begin
        if (cnt_q == C_HALF - 16'd1) begin
          cnt_d = 16'd0;
          bit_d = 3'd0;
          // line back high at mid start bit: a glitch, not a frame
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == C_FULL - 16'd1) begin
          cnt_d   = 16'd0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (cnt_q == C_FULL - 16'd1) begin
          cnt_d = 16'd0;
          st_d  = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // synchronizer preset to idle-high so reset release is not a start edge
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Purpose  : Receives a framed program image over UART (SYNC, LEN_LO,
//             LEN_HI, N little-endian words, XOR checksum) and writes it to
//             instruction memory; releases the core once the image checks.
//  Ports    : clk, reset (async active-low), rx,
//             imem_we/imem_addr[31:0]/imem_wdata[31:0] (write port),
//             core_run, load_err (sticky until next SYNC), busy
//  Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_run,
  output logic        load_err,
  output logic        busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [16:0] MAX_WORDS    = 17'(2 ** ADDR_WIDTH);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  boot_state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [15:0] widx_q, widx_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] len_full;
  logic        in_frame;

  assign len_full = {rx_byte, len_q[7:0]};
  assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHECK);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    word_d  = word_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
          csum_d  = 8'd0;
          bidx_d  = 2'd0;
          widx_d  = 16'd0;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_byte;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_byte;
          if ({1'b0, len_full} > MAX_WORDS) state_d = ST_ERROR;
          else if (len_full == 16'd0)        state_d = ST_CHECK;
          else                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_byte;
          // shift right so byte k of the word ends in bits [8k+7:8k]
          word_d = {rx_byte, word_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {14'd0, widx_q, 2'b00};
            wdata_d = {rx_byte, word_q[31:8]};
            widx_d  = widx_q + 16'd1;
            if (widx_q + 16'd1 == len_q) state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (rx_valid) state_d = (rx_byte == csum_q) ? ST_RUN : ST_ERROR;
      end
      default: ;
    endcase
    if (rx_ferr && in_frame) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= 16'd0;
      csum_q  <= 8'd0;
      word_q  <= 32'd0;
      bidx_q  <= 2'd0;
      widx_q  <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_run   = (state_q == ST_RUN);
  assign load_err   = (state_q == ST_ERROR);
  assign busy       = in_frame;

endmodule
`default_nettype wire
